// File: rtl/tx_inband_pkg.sv
// Shared definitions for the TX channel output stage: stop-FSM encoding,
// default widths and the saturating counter helper.
package tx_inband_pkg;

  localparam int MAX_CHAN      = 4;
  localparam int SAMPLE_W_DFLT = 16;
  localparam int TS_W_DFLT     = 32;
  localparam int RATE_W_DFLT   = 8;
  localparam int UCNT_W        = 16;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ARMED  = 2'd1,
    ST_HALTED = 2'd2
  } stop_state_e;

  function automatic logic [UCNT_W-1:0] sat_inc16(input logic [UCNT_W-1:0] v);
    if (v == {UCNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + UCNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/tx_strobe_decim.sv
// Strobe decimator: counts raw txstrobes, emits a one-cycle registered tick
// every strobe_rate+1 strobes and advances the shared timestamp on that edge.
module tx_strobe_decim
  import tx_inband_pkg::*;
#(
  parameter int RATE_W = RATE_W_DFLT,
  parameter int TS_W   = TS_W_DFLT
) (
  input  logic              txclk,
  input  logic              reset,
  input  logic              txstrobe_i,
  input  logic [RATE_W-1:0] strobe_rate_i,
  output logic              fire_o,
  output logic              tick_o,
  output logic [TS_W-1:0]   timestamp_o
);

  logic [RATE_W-1:0] dcnt_q, dcnt_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic              tick_q;

  // fire_o marks the edge that will register tick high; the top keys its
  // sample loads and the stop comparison off it.
  assign fire_o = txstrobe_i && (dcnt_q == strobe_rate_i);

  // Next-state for the decimation counter and timestamp.
  always_comb begin
    dcnt_d = dcnt_q;
    ts_d   = ts_q;
    if (fire_o) begin
      dcnt_d = '0;
      ts_d   = ts_q + TS_W'(1);
    end else if (txstrobe_i) begin
      dcnt_d = dcnt_q + RATE_W'(1);
    end else begin
      dcnt_d = dcnt_q;
    end
  end

  // State registers.
  always_ff @(posedge txclk) begin
    if (reset) begin
      dcnt_q <= '0;
      ts_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      dcnt_q <= dcnt_d;
      ts_q   <= ts_d;
      tick_q <= fire_o;
    end
  end

  assign tick_o      = tick_q;
  assign timestamp_o = ts_q;

endmodule

// File: rtl/tx_chan_output_stage.sv
// TX channel output stage: shared timestamp/tick, per-channel sample
// registers, space/empty aggregation, sticky underrun and timed stop.
// Optional macro TX_UNDERRUN_COUNT_EN adds saturating per-channel underrun counters.
module tx_chan_output_stage
  import tx_inband_pkg::*;
#(
  parameter int NUM_CHAN = 2,
  parameter int SAMPLE_W = SAMPLE_W_DFLT,
  parameter int TS_W     = TS_W_DFLT,
  parameter int RATE_W   = RATE_W_DFLT
) (
  input  logic                         txclk,
  input  logic                         reset,
  input  logic                         txstrobe,
  input  logic [RATE_W-1:0]            strobe_rate,
  input  logic [NUM_CHAN-1:0]          chan_en,
  input  logic [NUM_CHAN*SAMPLE_W-1:0] chan_i_in,
  input  logic [NUM_CHAN*SAMPLE_W-1:0] chan_q_in,
  input  logic [NUM_CHAN-1:0]          chan_empty_in,
  input  logic [NUM_CHAN-1:0]          chan_space_in,
  input  logic [NUM_CHAN-1:0]          chan_underrun_in,
  input  logic                         clear_status,
  input  logic                         stop_req,
  input  logic [TS_W-1:0]              stop_time_in,
  input  logic                         resume,
  output logic                         tick,
  output logic [TS_W-1:0]              timestamp,
  output logic [NUM_CHAN*SAMPLE_W-1:0] tx_i_out,
  output logic [NUM_CHAN*SAMPLE_W-1:0] tx_q_out,
  output logic                         have_space,
  output logic                         tx_empty,
  output logic [NUM_CHAN-1:0]          underrun_sticky,
`ifdef TX_UNDERRUN_COUNT_EN
  output logic [NUM_CHAN*UCNT_W-1:0]   underrun_count,
`endif
  output logic                         halted
);

  logic        fire;
  stop_state_e state_q;
  logic [TS_W-1:0] stop_time_q;
  logic        halted_q;
  logic        halt_enter;
  logic        blank;

  tx_strobe_decim #(
    .RATE_W (RATE_W),
    .TS_W   (TS_W)
  ) u_decim (
    .txclk         (txclk),
    .reset         (reset),
    .txstrobe_i    (txstrobe),
    .strobe_rate_i (strobe_rate),
    .fire_o        (fire),
    .tick_o        (tick),
    .timestamp_o   (timestamp)
  );

  // A stop_req or resume on the matching tick takes precedence over halting.
  assign halt_enter = (state_q == ST_ARMED) && fire && (timestamp == stop_time_q)
                      && !stop_req && !resume;
  assign blank      = (state_q == ST_HALTED) || halt_enter;

  // Timed-stop FSM with registered halted flag.
  always_ff @(posedge txclk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      stop_time_q <= '0;
      halted_q    <= 1'b0;
    end else if (stop_req) begin
      stop_time_q <= stop_time_in;
      state_q     <= ST_ARMED;
      halted_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          state_q  <= ST_RUN;
          halted_q <= 1'b0;
        end
        ST_ARMED: begin
          if (resume) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
          end else if (halt_enter) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end else begin
            state_q  <= ST_ARMED;
            halted_q <= 1'b0;
          end
        end
        ST_HALTED: begin
          if (resume) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
          end else begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign halted = halted_q;

  // Disabled channels are "don't care" for both aggregates.
  assign have_space = &(chan_space_in | ~chan_en);
  assign tx_empty   = &(chan_empty_in | ~chan_en);

  for (genvar k = 0; k < NUM_CHAN; k++) begin : g_chan
    logic [SAMPLE_W-1:0] i_q, i_d, q_q, q_d;
    logic                sticky_q, sticky_d;
    logic                qual_s;
    logic                pass_s;

    assign qual_s = chan_underrun_in[k] & chan_en[k];
    assign pass_s = chan_en[k] & ~chan_empty_in[k] & ~blank;

    // Sample load on tick edges, hold otherwise.
    always_comb begin
      i_d      = i_q;
      q_d      = q_q;
      sticky_d = qual_s | (sticky_q & ~clear_status);
      if (fire) begin
        if (pass_s) begin
          i_d = chan_i_in[k*SAMPLE_W +: SAMPLE_W];
          q_d = chan_q_in[k*SAMPLE_W +: SAMPLE_W];
        end else begin
          i_d = '0;
          q_d = '0;
        end
      end else begin
        i_d = i_q;
        q_d = q_q;
      end
    end

    // Per-channel registers.
    always_ff @(posedge txclk) begin
      if (reset) begin
        i_q      <= '0;
        q_q      <= '0;
        sticky_q <= 1'b0;
      end else begin
        i_q      <= i_d;
        q_q      <= q_d;
        sticky_q <= sticky_d;
      end
    end

    assign tx_i_out[k*SAMPLE_W +: SAMPLE_W] = i_q;
    assign tx_q_out[k*SAMPLE_W +: SAMPLE_W] = q_q;
    assign underrun_sticky[k]               = sticky_q;

`ifdef TX_UNDERRUN_COUNT_EN
    logic [UCNT_W-1:0] cnt_q, cnt_d;

    // Saturating counter; a qualified pulse beats clear_status.
    always_comb begin
      cnt_d = cnt_q;
      if (qual_s) begin
        cnt_d = sat_inc16(cnt_q);
      end else if (clear_status) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q;
      end
    end

    // Counter register.
    always_ff @(posedge txclk) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign underrun_count[k*UCNT_W +: UCNT_W] = cnt_q;
`endif
  end

endmodule

// File: tb/tb_tx_chan_output_stage.sv
// Self-checking bench for tx_chan_output_stage: behavioural model compared
// every cycle, plus directed vectors with hand-computed expectations.
module tb_tx_chan_output_stage;

  localparam int NC = 2;
  localparam int SW = 16;
  localparam int TW = 8;
  localparam int RW = 8;
  localparam int M_RUN = 0, M_ARMED = 1, M_HALT = 2;

  logic txclk = 1'b0;
  always #5 txclk = ~txclk;

  logic             reset;
  logic             txstrobe;
  logic [RW-1:0]    strobe_rate;
  logic [NC-1:0]    chan_en, chan_empty_in, chan_space_in, chan_underrun_in;
  logic [NC*SW-1:0] chan_i_in, chan_q_in;
  logic             clear_status, stop_req, resume;
  logic [TW-1:0]    stop_time_in;
  logic             tick, have_space, tx_empty, halted;
  logic [TW-1:0]    timestamp;
  logic [NC*SW-1:0] tx_i_out, tx_q_out;
  logic [NC-1:0]    underrun_sticky;
`ifdef TX_UNDERRUN_COUNT_EN
  logic [NC*16-1:0] underrun_count;
`endif

  tx_chan_output_stage #(
    .NUM_CHAN (NC), .SAMPLE_W (SW), .TS_W (TW), .RATE_W (RW)
  ) dut (
    .txclk            (txclk),
    .reset            (reset),
    .txstrobe         (txstrobe),
    .strobe_rate      (strobe_rate),
    .chan_en          (chan_en),
    .chan_i_in        (chan_i_in),
    .chan_q_in        (chan_q_in),
    .chan_empty_in    (chan_empty_in),
    .chan_space_in    (chan_space_in),
    .chan_underrun_in (chan_underrun_in),
    .clear_status     (clear_status),
    .stop_req         (stop_req),
    .stop_time_in     (stop_time_in),
    .resume           (resume),
    .tick             (tick),
    .timestamp        (timestamp),
    .tx_i_out         (tx_i_out),
    .tx_q_out         (tx_q_out),
    .have_space       (have_space),
    .tx_empty         (tx_empty),
    .underrun_sticky  (underrun_sticky),
`ifdef TX_UNDERRUN_COUNT_EN
    .underrun_count   (underrun_count),
`endif
    .halted           (halted)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            m_valid = 1'b0;
  int            m_cnt, m_ts, m_mode, m_stop;
  bit            m_tick;
  logic [SW-1:0] m_i[NC];
  logic [SW-1:0] m_q[NC];
  bit            m_sticky[NC];
  int            m_ucnt[NC];

  initial begin : model
    bit fire, blank;
    int nmode;
    forever begin
      @(posedge txclk);
      if (reset) begin
        m_valid = 1'b1;
        m_cnt = 0; m_ts = 0; m_mode = M_RUN; m_stop = 0; m_tick = 1'b0;
        for (int k = 0; k < NC; k++) begin
          m_i[k] = '0; m_q[k] = '0; m_sticky[k] = 1'b0; m_ucnt[k] = 0;
        end
      end else begin
        fire = txstrobe && (m_cnt == int'(strobe_rate));
        if (txstrobe) m_cnt = fire ? 0 : (m_cnt + 1) % (1 << RW);
        nmode = m_mode;
        if (stop_req) begin
          m_stop = int'(stop_time_in);
          nmode  = M_ARMED;
        end else if (resume && m_mode != M_RUN) begin
          nmode = M_RUN;
        end else if (m_mode == M_ARMED && fire && m_ts == m_stop) begin
          nmode = M_HALT;
        end
        blank = (m_mode == M_HALT) || (nmode == M_HALT);
        if (fire) begin
          for (int k = 0; k < NC; k++) begin
            if (chan_en[k] && !chan_empty_in[k] && !blank) begin
              m_i[k] = chan_i_in[k*SW +: SW];
              m_q[k] = chan_q_in[k*SW +: SW];
            end else begin
              m_i[k] = '0;
              m_q[k] = '0;
            end
          end
          m_ts = (m_ts + 1) % (1 << TW);
        end
        m_tick = fire;
        for (int k = 0; k < NC; k++) begin
          if (chan_underrun_in[k] && chan_en[k]) begin
            m_sticky[k] = 1'b1;
            m_ucnt[k]   = (m_ucnt[k] < 65535) ? m_ucnt[k] + 1 : 65535;
          end else if (clear_status) begin
            m_sticky[k] = 1'b0;
            m_ucnt[k]   = 0;
          end
        end
        m_mode = nmode;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    logic [NC*SW-1:0] ei, eq;
    logic [NC-1:0]    es;
    bit               hs, te;
    forever begin
      @(negedge txclk);
      if (m_valid) begin
        hs = 1'b1; te = 1'b1;
        for (int k = 0; k < NC; k++) begin
          ei[k*SW +: SW] = m_i[k];
          eq[k*SW +: SW] = m_q[k];
          es[k]          = m_sticky[k];
          if (chan_en[k] && !chan_space_in[k]) hs = 1'b0;
          if (chan_en[k] && !chan_empty_in[k]) te = 1'b0;
        end
        chk("tick", tick, m_tick);
        chk("timestamp", timestamp, m_ts[TW-1:0]);
        chk("tx_i_out", tx_i_out, ei);
        chk("tx_q_out", tx_q_out, eq);
        chk("halted", halted, m_mode == M_HALT);
        chk("underrun_sticky", underrun_sticky, es);
        chk("have_space", have_space, hs);
        chk("tx_empty", tx_empty, te);
`ifdef TX_UNDERRUN_COUNT_EN
        for (int k = 0; k < NC; k++)
          chk("underrun_count", underrun_count[k*16 +: 16], m_ucnt[k][15:0]);
`endif
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge txclk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin : stim
    int nt;
    int hit;
    reset = 1'b1; txstrobe = 1'b0; strobe_rate = '0; chan_en = '0;
    chan_i_in = '0; chan_q_in = '0; chan_empty_in = '0; chan_space_in = '0;
    chan_underrun_in = '0; clear_status = 1'b0; stop_req = 1'b0;
    stop_time_in = '0; resume = 1'b0;
    step(2);
    reset = 1'b0;
    chk("rst_tick", tick, 1'b0);
    chk("rst_ts", timestamp, 8'd0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_tx_i", tx_i_out, 32'd0);
    chk("rst_have_space", have_space, 1'b1);

    // 1: rate 0, ten strobes
    strobe_rate = 8'd0;
    txstrobe = 1'b1;
    #1 chk("t1_no_tick_yet", tick, 1'b0);
    nt = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 1) chk("t1_first_tick", tick, 1'b1);
      if (tick) nt++;
    end
    txstrobe = 1'b0;
    chk("t1_tick_count", nt, 10);
    chk("t1_ts", timestamp, 8'd10);
    step();
    chk("t1_tick_drop", tick, 1'b0);

    // 2: rate 3, sixteen strobes
    do_reset();
    strobe_rate = 8'd3;
    txstrobe = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("t2_tick_pos", tick, (i % 4) == 0);
    end
    txstrobe = 1'b0;
    chk("t2_ts", timestamp, 8'd4);

    // 3: masking and aggregation
    strobe_rate = 8'd0;
    chan_en = 2'b01; chan_empty_in = 2'b10; chan_space_in = 2'b01;
    chan_i_in = {16'h5678, 16'h1234};
    chan_q_in = {16'h9abc, 16'hdef0};
    #1;
    chk("t3_have_space", have_space, 1'b1);
    chk("t3_tx_empty", tx_empty, 1'b0);
    txstrobe = 1'b1;
    step();
    txstrobe = 1'b0;
    chk("t3_tx_i", tx_i_out, 32'h0000_1234);
    chk("t3_tx_q", tx_q_out, 32'h0000_def0);
    chan_i_in = {16'h1111, 16'h2222};
    step(2);
    chk("t3_hold", tx_i_out, 32'h0000_1234);
    chan_en = 2'b00;
    #1;
    chk("t3_none_space", have_space, 1'b1);
    chk("t3_none_empty", tx_empty, 1'b1);
    chan_en = 2'b11;
    #1;
    chk("t3_both_space", have_space, 1'b0);

    // 4: sticky underrun
    chan_underrun_in = 2'b10; clear_status = 1'b1;
    step();
    chan_underrun_in = 2'b00;
    chk("t4_set_wins", underrun_sticky, 2'b10);
    step();
    clear_status = 1'b0;
    chk("t4_cleared", underrun_sticky, 2'b00);
    chan_en = 2'b01; chan_underrun_in = 2'b10;
    step();
    chan_underrun_in = 2'b00;
    chk("t4_masked", underrun_sticky, 2'b00);

    // 5: timed stop at timestamp 5
    do_reset();
    chan_en = 2'b11; chan_empty_in = 2'b00; chan_space_in = 2'b11;
    chan_i_in = {16'h5678, 16'h1234};
    strobe_rate = 8'd0;
    txstrobe = 1'b1;
    step(2);
    chk("t5_ts_start", timestamp, 8'd2);
    stop_req = 1'b1; stop_time_in = 8'd5;
    step();
    stop_req = 1'b0;
    hit = 0;
    for (int i = 0; i < 20; i++) begin
      if (halted) begin
        hit = 1;
        break;
      end
      step();
    end
    chk("t5_halted", hit, 1);
    chk("t5_ts_at_halt", timestamp, 8'd6);
    chk("t5_zeroed", tx_i_out, 32'd0);
    txstrobe = 1'b0; resume = 1'b1;
    step();
    resume = 1'b0;
    chk("t5_resumed", halted, 1'b0);
    txstrobe = 1'b1;
    step();
    txstrobe = 1'b0;
    chk("t5_pass", tx_i_out, 32'h5678_1234);
    // ARMED then cancelled: never halts
    stop_req = 1'b1; stop_time_in = 8'd9;
    step();
    stop_req = 1'b0; resume = 1'b1;
    step();
    resume = 1'b0; txstrobe = 1'b1;
    step(6);
    txstrobe = 1'b0;
    chk("t5_cancel", halted, 1'b0);

    // 6: timestamp wrap
    do_reset();
    strobe_rate = 8'd0;
    txstrobe = 1'b1;
    step(255);
    chk("t6_ts_max", timestamp, 8'hff);
    step();
    chk("t6_ts_wrap", timestamp, 8'h00);
    step();
    txstrobe = 1'b0;
    chk("t6_ts_one", timestamp, 8'h01);

    // 7: rate lowered below the running count
    do_reset();
    strobe_rate = 8'd5;
    txstrobe = 1'b1;
    step(3);
    strobe_rate = 8'd1;
    hit = 0;
    for (int i = 1; i <= 400; i++) begin
      step();
      if (tick) begin
        hit = i;
        break;
      end
    end
    txstrobe = 1'b0;
    chk("t7_wrap_match", hit, 255);

    // midstream reset: no tick after reset edge
    txstrobe = 1'b1; strobe_rate = 8'd0;
    step(3);
    do_reset();
    chk("rst_mid_tick", tick, 1'b0);
    chk("rst_mid_ts", timestamp, 8'd0);
    txstrobe = 1'b0;

`ifdef TX_UNDERRUN_COUNT_EN
    // 8: saturating underrun counter
    do_reset();
    chan_en = 2'b01; chan_underrun_in = 2'b01; clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    chk("t8_inc_wins", underrun_count[15:0], 16'd1);
    step(65535);
    chk("t8_sat", underrun_count[15:0], 16'hffff);
    step();
    chk("t8_sat_hold", underrun_count[15:0], 16'hffff);
    chk("t8_other", underrun_count[31:16], 16'd0);
    chan_underrun_in = 2'b00; clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    chk("t8_clear", underrun_count[15:0], 16'd0);
`endif

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tx_chan_output_stage.md
Name: tx_chan_output_stage

Overview:
- Parametrised output stage between the per-channel FIFO readers and the NUM_CHAN TX DSP chains.
- Owns the shared 32-bit timestamp counter with programmable strobe decimation.
- Registers and masks per-channel I/Q samples, and aggregates have_space/tx_empty over the enabled channels only.
- Keeps sticky underrun status, and runs a timed-stop state machine that halts all channels when a programmed timestamp is reached.

Parameters:
- NUM_CHAN, 2, number of TX data channels (1..4).
- SAMPLE_W, 16, width of each I and Q sample.
- TS_W, 32, timestamp counter width.
- RATE_W, 8, width of the strobe decimation value.

Ports:
- txclk  in  1  TX clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- txstrobe  in  1  raw sample strobe from the TX chain.
- strobe_rate  in  RATE_W  decimation value; one tick every strobe_rate+1 txstrobes.
- chan_en  in  NUM_CHAN  per-channel enable mask.
- chan_i_in  in  NUM_CHAN*SAMPLE_W  reader I samples; channel k in bits [k*SAMPLE_W +: SAMPLE_W].
- chan_q_in  in  NUM_CHAN*SAMPLE_W  reader Q samples; same packing as chan_i_in.
- chan_empty_in  in  NUM_CHAN  reader has no valid sample.
- chan_space_in  in  NUM_CHAN  channel RAM can accept a packet.
- chan_underrun_in  in  NUM_CHAN  single-cycle underrun pulse from the reader.
- clear_status  in  1  clears the sticky underrun bits.
- stop_req  in  1  pulse; arms a timed stop at stop_time_in.
- stop_time_in  in  TS_W  stop timestamp; latched on stop_req.
- resume  in  1  pulse; leaves HALTED.
- tick  out  1  decimated sample strobe to the readers.
- timestamp  out  TS_W  current timestamp.
- tx_i_out  out  NUM_CHAN*SAMPLE_W  registered I samples.
- tx_q_out  out  NUM_CHAN*SAMPLE_W  registered Q samples.
- have_space  out  1  AND of chan_space_in over enabled channels.
- tx_empty  out  1  AND of chan_empty_in over enabled channels.
- underrun_sticky  out  NUM_CHAN  sticky per-channel underrun.
- halted  out  1  FSM is in HALTED.

Behaviour:
- Reset values:
  - all outputs 0, except have_space and tx_empty, which follow their combinational definitions;
  - decimation counter 0; FSM in RUN.
- Decimation:
  - 8-bit counter dcnt advances on each txstrobe.
  - When txstrobe=1 and dcnt==strobe_rate, tick is registered high for exactly one cycle and dcnt returns to 0. Otherwise, on txstrobe, dcnt increments.
  - strobe_rate=0 gives tick = txstrobe delayed by 1 cycle.
  - If strobe_rate is lowered below dcnt, the counter keeps counting, wraps at 2^RATE_W, then matches.
- Timestamp:
  - Increments by 1 on the same edge that registers tick high.
  - Wraps from all-ones to 0.
  - Keeps counting in every FSM state.
- Samples:
  - On the edge that registers tick high, channel k is loaded with chan_i/q_in, or with 0 if chan_en[k]=0, chan_empty_in[k]=1, or the FSM is in HALTED (including the edge that enters HALTED).
  - Between ticks the outputs hold.
  - Latency: txstrobe to output is 1 cycle.
- Aggregation:
  - have_space and tx_empty are combinational.
  - With chan_en all 0, both are 1.
- Sticky underrun:
  - Bit k is set on chan_underrun_in[k] & chan_en[k].
  - clear_status clears all bits; a set in the same cycle wins.
- Stop FSM, states RUN, ARMED, HALTED:
  - RUN: stop_req latches stop_time_in and moves to ARMED.
  - ARMED: a further stop_req re-latches the stop time. On the tick edge where the pre-increment timestamp equals the latched value, go to HALTED.
  - HALTED: sample outputs zeroed; resume goes to RUN. stop_req in HALTED re-latches and goes to ARMED.
  - stop_req and resume together: stop_req wins.
  - resume in RUN or ARMED: ignored in RUN; in ARMED it cancels the stop and goes to RUN.
- Reset mid-operation clears all state within one cycle; no partial tick is emitted.

Optional Feature:
- Macro: TX_UNDERRUN_COUNT_EN.
- Defined: adds output underrun_count, NUM_CHAN*16 bits. Each channel has a 16-bit counter that saturates at 0xFFFF, increments on each qualified underrun pulse, and is cleared by clear_status (the increment wins in the same cycle).
- Undefined: the port is absent; only underrun_sticky is provided.

Decomposition:
- Shared package tx_inband_pkg:
  - FSM state encoding (RUN=2'd0, ARMED=2'd1, HALTED=2'd2);
  - default widths SAMPLE_W, TS_W, RATE_W;
  - MAX_CHAN=4.
- One sub-module: tx_strobe_decim, containing the decimation counter, tick register and timestamp counter.
- The per-channel logic is a generate loop in the top.

Test Plan:
1. strobe_rate=0, txstrobe held high 10 cycles → tick high 10 cycles starting 1 cycle late; timestamp=10.
2. strobe_rate=3, txstrobe every cycle for 16 cycles → 4 ticks spaced 4 cycles apart; timestamp=4.
3. NUM_CHAN=2, chan_en=2'b01, chan_empty_in=2'b10, chan_i_in ch0=0x1234, ch1=0x5678 → ch0 output 0x1234, ch1 output 0. chan_space_in=2'b01 → have_space=1. With chan_en=0 → have_space=1 and tx_empty=1.
4. chan_underrun_in[1] pulses in the same cycle as clear_status → underrun_sticky=2'b10. Next cycle clear_status alone → 2'b00.
5. stop_req with stop_time_in=5 at timestamp 2 → halted=1 after the tick where timestamp 5→6; outputs 0 on that tick; resume → RUN, samples pass on the next tick.
6. Timestamp preloaded near 0xFFFFFFFF via ticks → wraps to 0. Under TX_UNDERRUN_COUNT_EN, 0x10000 underrun pulses → count stays 0xFFFF.
